loop_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the loop-accumulation datapath. It accepts one job (`in1`, `in2`) through a valid/ready handshake and runs two loops, one iteration per clock, over a single shared adder and a single shared multiplier. The first loop is a bounded sum, the second a clamped running product. Results are presented through an output valid/ready handshake. The block sits between a job producer and a result consumer, and replaces the fully unrolled combinational form of the same loops where area matters more than latency.

---
 rtl/loop_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_loop_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_seq_ctrl.sv
// ---------------------------------------------------------------------------
// loop_seq_ctrl
//
// Sequencer for the loop-accumulation datapath. One job (in1, in2) is taken
// through a valid/ready handshake, then two loops run one iteration per clock
// over a single shared adder and a single shared multiplier:
//   sum loop  : sum += in1 + i,  i = 0 .. SUM_ITERS-1
//   prod loop : prod *= i,       i = 1 .. n, n = clamp(in2, 0, PROD_MAX)
// The results are held on out1/out2 until the consumer takes them.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous, active-high reset
//   in_valid   - job request
//   in_ready   - block is idle and can take a job
//   in1        - signed sum operand (W bits)
//   in2        - signed product-loop bound (W bits)
//   abort      - synchronous cancel of a running job (ignored in IDLE/DONE
//                except that it blocks an accept in IDLE)
//   out_valid  - result valid (DONE state)
//   out_ready  - consumer accepts the result
//   out1       - sum result (W bits, wrap-around)
//   out2       - product result n! (low W bits)
//   busy       - a loop is running
//   job_count  - completed output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module loop_seq_ctrl #(
    parameter int W         = 32,
    parameter int SUM_ITERS = 5,
    parameter int PROD_MAX  = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic         busy,
    output logic [15:0]  job_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_PROD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] ZERO   = {W{1'b0}};
    localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] LAST_I = W'(SUM_ITERS - 1);
    localparam logic [W-1:0] PMAX   = W'(PROD_MAX);

    state_t         state_r;
    state_t         state_s;
    logic           accept_s;
    logic           drain_s;

    logic [W-1:0]   in1_q_r;
    logic [W-1:0]   n_r;
    logic [W-1:0]   i_r;
    logic [W-1:0]   sum_r;
    logic [W-1:0]   prod_r;
    logic [W-1:0]   out1_r;
    logic [W-1:0]   out2_r;
    logic [15:0]    job_count_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           busy_r;

    logic [W-1:0]   n_clamp_s;
    logic [W-1:0]   sum_next_s;
    logic [W-1:0]   mul_s;

    // Shared arithmetic: one adder chain for the sum loop, one multiplier
    // for the product loop; both wrap at W bits.
    assign sum_next_s = sum_r + in1_q_r + i_r;
    assign mul_s      = prod_r * i_r;

    // Product-loop bound: negative or zero gives an empty loop, large values
    // are clamped so the loop length stays bounded.
    always_comb begin
        n_clamp_s = ZERO;
        if (in2[W-1] || (in2 == ZERO)) begin
            n_clamp_s = ZERO;
        end else if ($signed(in2) > $signed(PMAX)) begin
            n_clamp_s = PMAX;
        end else begin
            n_clamp_s = in2;
        end
    end

    // Next-state decode; abort wins over accept in IDLE and cancels the loops.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        drain_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (in_valid) begin
                    state_s  = ST_SUM;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SUM: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (i_r == LAST_I) begin
                    if (n_r == ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_PROD;
                    end
                end else begin
                    state_s = ST_SUM;
                end
            end
            ST_PROD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (i_r == n_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_PROD;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                    drain_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags registered from the next state so they line up with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s == ST_SUM) || (state_s == ST_PROD);
        end
    end

    // Loop datapath: operand capture, iteration counter, accumulators and
    // result registers. Results only change when a loop completes, so an
    // aborted job leaves the previous result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q_r <= ZERO;
            n_r     <= ZERO;
            i_r     <= ZERO;
            sum_r   <= ZERO;
            prod_r  <= ZERO;
            out1_r  <= ZERO;
            out2_r  <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in1_q_r <= in1;
                        n_r     <= n_clamp_s;
                        sum_r   <= ZERO;
                        i_r     <= ZERO;
                    end
                end
                ST_SUM: begin
                    if (!abort) begin
                        sum_r <= sum_next_s;
                        if (i_r == LAST_I) begin
                            if (n_r == ZERO) begin
                                // Empty product loop: 0! = 1.
                                out1_r <= sum_next_s;
                                out2_r <= ONE;
                            end else begin
                                prod_r <= ONE;
                                i_r    <= ONE;
                            end
                        end else begin
                            i_r <= i_r + ONE;
                        end
                    end
                end
                ST_PROD: begin
                    if (!abort) begin
                        prod_r <= mul_s;
                        if (i_r == n_r) begin
                            out1_r <= sum_r;
                            out2_r <= mul_s;
                        end else begin
                            i_r <= i_r + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Results are held until drained.
                end
                default: begin
                    i_r <= ZERO;
                end
            endcase
        end
    end

    // Completed-job counter, stepped only on the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_count_r <= 16'd0;
        end else if (drain_s) begin
            job_count_r <= job_count_r + 16'd1;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out1      = out1_r;
    assign out2      = out2_r;
    assign job_count = job_count_r;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_loop_seq_ctrl
//
// Self-checking bench for loop_seq_ctrl with default parameters: a table of
// directed jobs, hand-written backpressure / abort / reset sequences, and
// random jobs checked against closed-form results (sum formula, factorial
// table, clamp rule).
// ---------------------------------------------------------------------------
module tb_loop_seq_ctrl;

    localparam int SUM_ITERS = 5;
    localparam int PROD_MAX  = 7;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        busy;
    logic [15:0] job_count;

    int total;
    int bad;
    int exp_jc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e1;
        logic [31:0] e2;
        int          elat;
    } vec_t;

    vec_t vecs[7];

    loop_seq_ctrl #(.W(32), .SUM_ITERS(SUM_ITERS), .PROD_MAX(PROD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .busy      (busy),
        .job_count (job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int model_n(input logic [31:0] b);
        if ($signed(b) < 1) return 0;
        if ($signed(b) > PROD_MAX) return PROD_MAX;
        return int'(b);
    endfunction

    function automatic logic [31:0] model_sum(input logic [31:0] a);
        return 32'(SUM_ITERS) * a + 32'(SUM_ITERS * (SUM_ITERS - 1) / 2);
    endfunction

    function automatic logic [31:0] model_fact(input int n);
        logic [31:0] f [8];
        f = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040};
        return f[n];
    endfunction

    // Runs one job with out_ready high; returns results, edge latency from
    // accept to out_valid, and number of cycles busy was high.
    task automatic do_job(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] o1, output logic [31:0] o2,
                          output int lat, output int bcnt);
        @(negedge clk);
        in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom;
        lat = 0; bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        o1 = out1; o2 = out2;
        @(posedge clk); #1;
        exp_jc++;
        check("drain_valid_low", {31'd0, out_valid}, 32'd0);
        check("drain_ready_high", {31'd0, in_ready}, 32'd1);
        check("job_count", {16'd0, job_count}, 32'(exp_jc & 16'hFFFF));
    endtask

    initial begin
        logic [31:0] o1, o2, a, b, e1, e2;
        int lat, bcnt, n, cyc;

        total = 0; bad = 0; exp_jc = 0;
        vecs[0] = '{32'd3,          32'd4,          32'd25,         32'd24,   9};
        vecs[1] = '{32'hFFFFFFFE,   32'd0,          32'd0,          32'd1,    5};
        vecs[2] = '{32'hFFFFFFFE,   32'hFFFFFFFB,   32'd0,          32'd1,    5};
        vecs[3] = '{32'd0,          32'd100,        32'd10,         32'd5040, 12};
        vecs[4] = '{32'h7FFFFFFF,   32'd0,          32'h80000005,   32'd1,    5};
        vecs[5] = '{32'd1,          32'd7,          32'd15,         32'd5040, 12};
        vecs[6] = '{32'd0,          32'd1,          32'd10,         32'd1,    6};

        rst = 1'b1; in_valid = 1'b0; in1 = 32'd0; in2 = 32'd0;
        abort = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_out2", out2, 32'd0);
        check("rst_job_count", {16'd0, job_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table.
        for (int k = 0; k < 7; k++) begin
            do_job(vecs[k].a, vecs[k].b, o1, o2, lat, bcnt);
            check("vec_out1", o1, vecs[k].e1);
            check("vec_out2", o2, vecs[k].e2);
            check("vec_latency", 32'(lat), 32'(vecs[k].elat));
            check("vec_busy_cycles", 32'(bcnt), 32'(vecs[k].elat));
        end

        // Backpressure: result held while the consumer stalls.
        @(negedge clk);
        in1 = 32'd5; in2 = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd7);
        check("bp_out1", out1, 32'd35);
        check("bp_out2", out2, 32'd2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0]; in1 = $urandom; in2 = $urandom;
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_out1", out1, 32'd35);
            check("bp_hold_out2", out2, 32'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_job_count", {16'd0, job_count}, 32'(exp_jc));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        exp_jc++;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_count", {16'd0, job_count}, 32'(exp_jc));

        // Abort during sum iteration 2.
        @(negedge clk);
        in1 = 32'd9; in2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        check("abort_out1", out1, 32'd35);
        check("abort_out2", out2, 32'd2);
        check("abort_count", {16'd0, job_count}, 32'(exp_jc));

        // Abort together with in_valid in IDLE: no accept.
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in1 = 32'd1; in2 = 32'd1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        check("idle_abort_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("idle_abort_no_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of the product loop.
        @(negedge clk);
        in1 = 32'd2; in2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out1", out1, 32'd0);
        check("arst_out2", out2, 32'd0);
        check("arst_job_count", {16'd0, job_count}, 32'd0);
        #1;
        rst = 1'b0;
        exp_jc = 0;
        do_job(32'd1, 32'd7, o1, o2, lat, bcnt);
        check("post_rst_out1", o1, 32'd15);
        check("post_rst_out2", o2, 32'd5040);
        check("post_rst_latency", 32'(lat), 32'd12);

        // Random jobs against the closed-form model.
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom;
            else b = 32'($urandom_range(0, 12)) - 32'd3;
            n  = model_n(b);
            e1 = model_sum(a);
            e2 = model_fact(n);
            do_job(a, b, o1, o2, lat, bcnt);
            check("rnd_out1", o1, e1);
            check("rnd_out2", o2, e2);
            check("rnd_latency", 32'(lat), 32'(SUM_ITERS + n));
            check("rnd_busy_cycles", 32'(bcnt), 32'(SUM_ITERS + n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
